// File: rtl/conv_pkg.sv
// Shared sizing helpers for the convolution engine and its output FIFO.
// No logic of its own; all functions are elaboration-time only.
// Backpressure: not applicable.
package conv_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int ntaps(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Coefficient address width: one extra code above the last tap is the commit strobe.
    function automatic int addr_w(input int rows, input int cols);
        return clog2(rows * cols + 1);
    endfunction

    // Full-precision accumulator width: product width plus growth of the adder tree.
    function automatic int acc_w(input int sw, input int cw, input int rows, input int cols);
        return sw + cw + clog2(rows * cols);
    endfunction

    localparam int ACCW_DEF = acc_w(40, 33, 7, 5);
    typedef logic signed [ACCW_DEF-1:0] sum_t;

endpackage

// File: rtl/conv_ofifo.sv
// Synchronous output FIFO with a registered first-word-fall-through head.
// Latency: a write lands in storage at one edge and reaches the head register at the next.
// Backpressure: head is held while rd_rdy=0; the caller must never write into a full FIFO.
module conv_ofifo
    import conv_pkg::*;
#(
    parameter int WIDTH = 45,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [clog2(DEPTH):0]    count
);

    localparam int PTRW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wptr_q;
    logic [PTRW-1:0]  rptr_q;
    logic [PTRW:0]    mcnt_q;
    logic             load;
    logic             take;

    // Head reloads when it is empty or being popped; take only if storage has data.
    assign load  = !rd_vld || rd_rdy;
    assign take  = load && (mcnt_q != '0);
    assign count = mcnt_q + {{PTRW{1'b0}}, rd_vld};

    // Storage array, written unconditionally on wr_vld.
    always_ff @(posedge clk) begin
        if (wr_vld) mem[wptr_q] <= wr_dat;
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mcnt_q <= '0;
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            if (wr_vld) wptr_q <= wptr_q + PTRW'(1);
            if (take) begin
                rd_dat <= mem[rptr_q];
                rptr_q <= rptr_q + PTRW'(1);
            end
            if (load) rd_vld <= take;
            mcnt_q <= mcnt_q + (PTRW+1)'(wr_vld) - (PTRW+1)'(take);
        end
    end

endmodule

// File: rtl/conv_rxc_pipe.sv
// ROWSxCOLS signed convolution: window x coefficients, registered adder tree, FWFT result FIFO.
// Latency: 1+MUL_STAGES+clog2(NTAPS) edges from accept to FIFO write, result visible one edge later.
// Backpressure: samp_ready credits FIFO space incl. in-flight windows; pushes while not ready set sticky err.
module conv_rxc_pipe
    import conv_pkg::*;
#(
    parameter int ROWS       = 7,
    parameter int COLS       = 5,
    parameter int SW         = 40,
    parameter int CW         = 33,
    parameter int RW         = 45,
    parameter int SHIFT      = 0,
    parameter int MUL_STAGES = 2,
    parameter int FIFO_DEPTH = 32,
    parameter int DBUF       = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [addr_w(ROWS,COLS)-1:0]   ca,
    input  logic [CW-1:0]                  cd,
    input  logic                           cw,
    input  logic                           push_samp,
    input  logic [ROWS*COLS*SW-1:0]        samp,
    output logic                           samp_ready,
    output logic                           pushout,
    input  logic                           stopout,
    output logic [RW-1:0]                  res,
    output logic                           err
);

    localparam int NTAPS = ntaps(ROWS, COLS);
    localparam int AW    = addr_w(ROWS, COLS);
    localparam int L     = clog2(NTAPS);
    localparam int P2    = 1 << L;
    localparam int PW    = SW + CW;
    localparam int ACCW  = acc_w(SW, CW, ROWS, COLS);
    localparam int LAT   = 1 + MUL_STAGES + L;
    localparam int CNTW  = clog2(FIFO_DEPTH) + 1;
    localparam logic [CNTW:0] DEPTH_C = (CNTW+1)'(FIFO_DEPTH);

    logic signed [CW-1:0]   act_q   [NTAPS];
    logic signed [CW-1:0]   shd_q   [NTAPS];
    logic signed [CW-1:0]   act_nxt [NTAPS];
    logic signed [SW-1:0]   s0_samp [NTAPS];
    logic signed [CW-1:0]   s0_coef [NTAPS];
    logic signed [PW-1:0]   mul_q   [MUL_STAGES][NTAPS];
    logic signed [ACCW-1:0] leaf    [P2];
    logic signed [ACCW-1:0] tree_q  [L][P2/2];
    logic [LAT-1:0]         vld_q;
    logic                   run_q;
    logic [CNTW-1:0]        inflight_q;
    logic [CNTW-1:0]        fifo_count;
    logic                   accept;
    logic                   wr_vld;
    logic [RW-1:0]          wr_dat;
    logic                   pop_rdy;

    // Credit check uses only flops so samp_ready has no path from any input.
    assign samp_ready = run_q && (({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_C);
    assign accept     = push_samp && samp_ready;
    assign wr_vld     = vld_q[LAT-1];
    assign wr_dat     = RW'(tree_q[L-1][0] >>> SHIFT);
    assign pop_rdy    = !stopout;

    // Active bank as seen by a window accepted this cycle: includes a same-cycle write or commit.
    always_comb begin
        for (int t = 0; t < NTAPS; t++) act_nxt[t] = act_q[t];
        if (cw) begin
            if (DBUF == 0 && ca < AW'(NTAPS)) begin
                act_nxt[ca] = cd;
            end else if (DBUF != 0 && ca == AW'(NTAPS)) begin
                for (int t = 0; t < NTAPS; t++) act_nxt[t] = shd_q[t];
            end
        end
    end

    // Coefficient banks: shadow takes tap writes when double-buffered, active follows act_nxt.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NTAPS; t++) begin
                act_q[t] <= '0;
                shd_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NTAPS; t++) act_q[t] <= act_nxt[t];
            if (DBUF != 0 && cw && ca < AW'(NTAPS)) shd_q[ca] <= cd;
        end
    end

    // Datapath: capture window and coefficients, multiply pipeline, then binary adder tree.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NTAPS; t++) begin
            s0_samp[t]  <= samp[t*SW +: SW];
            s0_coef[t]  <= act_nxt[t];
            mul_q[0][t] <= PW'(s0_samp[t]) * PW'(s0_coef[t]);
            for (int m = 1; m < MUL_STAGES; m++) mul_q[m][t] <= mul_q[m-1][t];
        end
        for (int i = 0; i < P2/2; i++) tree_q[0][i] <= leaf[2*i] + leaf[2*i+1];
        for (int k = 1; k < L; k++) begin
            for (int i = 0; i < (P2 >> (k+1)); i++) begin
                tree_q[k][i] <= tree_q[k-1][2*i] + tree_q[k-1][2*i+1];
            end
        end
    end

    // Tree leaves: sign-extended products, zero-padded up to a power of two.
    for (genvar i = 0; i < P2; i++) begin : g_leaf
        if (i < NTAPS) begin : g_tap
            assign leaf[i] = ACCW'(mul_q[MUL_STAGES-1][i]);
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    // Valid pipeline, in-flight credit count, post-reset enable and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q      <= '0;
            run_q      <= 1'b0;
            inflight_q <= '0;
            err        <= 1'b0;
        end else begin
            vld_q      <= {vld_q[LAT-2:0], accept};
            run_q      <= 1'b1;
            inflight_q <= inflight_q + CNTW'(accept) - CNTW'(wr_vld);
            if (push_samp && !samp_ready) err <= 1'b1;
        end
    end

    conv_ofifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_ofifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (wr_vld),
        .wr_dat (wr_dat),
        .rd_vld (pushout),
        .rd_rdy (pop_rdy),
        .rd_dat (res),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_conv_rxc_pipe.sv
// Directed bench for conv_rxc_pipe at default parameters.
// Table of single-window vectors plus sequences for double buffering, credit, overflow and reset.
// Results are compared against hand-computed values and a scaled-sum stream model.
module tb_conv_rxc_pipe;

    localparam int NT = 35;
    localparam int SW = 40;
    localparam int CW = 33;
    localparam int RW = 45;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        ca;
    logic [CW-1:0]     cd;
    logic              cw;
    logic              push_samp;
    logic [NT*SW-1:0]  samp;
    logic              samp_ready;
    logic              pushout;
    logic              stopout;
    logic [RW-1:0]     res;
    logic              err;

    int checks   = 0;
    int failures = 0;
    logic [RW-1:0] exp_q [$];

    typedef struct {
        longint      c_all;
        int          c_tap;
        longint      c_val;
        longint      s_all;
        int          s_tap;
        longint      s_val;
        logic [RW-1:0] exp;
    } vec_t;

    vec_t vecs [7];

    conv_rxc_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .ca         (ca),
        .cd         (cd),
        .cw         (cw),
        .push_samp  (push_samp),
        .samp       (samp),
        .samp_ready (samp_ready),
        .pushout    (pushout),
        .stopout    (stopout),
        .res        (res),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [NT*SW-1:0] build_win(input longint s_all, input int tap, input longint s_val);
        logic [NT*SW-1:0] w;
        for (int t = 0; t < NT; t++) w[t*SW +: SW] = (t == tap) ? SW'(s_val) : SW'(s_all);
        return w;
    endfunction

    task automatic load_coefs(input longint c_all, input int tap, input longint c_val);
        cw = 1'b1;
        for (int t = 0; t < NT; t++) begin
            ca = 6'(t);
            cd = (t == tap) ? CW'(c_val) : CW'(c_all);
            tick();
        end
        ca = 6'(NT);
        tick();
        cw = 1'b0;
        ca = '0;
    endtask

    // Pushes n_push windows (value v on every tap, expected k*v) while popping under random stall.
    task automatic run_stream(input int n_push, input int stop_pct, input int k, input int base, input int budget);
        int pushed;
        int cyc;
        int v;
        logic [RW-1:0] e;
        pushed = 0;
        cyc = 0;
        while ((pushed < n_push || exp_q.size() > 0) && cyc < budget) begin
            stopout = ($urandom_range(99) < stop_pct);
            if (pushout && !stopout) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_pop", 64'(pushout), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_res", 64'(res), 64'(e));
                end
            end
            if (pushed < n_push && samp_ready) begin
                v = base + pushed * 37;
                push_samp = 1'b1;
                samp = build_win(longint'(v), -1, 0);
                exp_q.push_back(RW'(k * v));
                pushed++;
            end else begin
                push_samp = 1'b0;
            end
            tick();
            cyc++;
        end
        push_samp = 1'b0;
        stopout = 1'b0;
        check("stream_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        int first_block;
        int cnt;

        vecs[0] = '{c_all: 0,  c_tap: 17, c_val: 1,  s_all: 0,  s_tap: 17, s_val: -5,  exp: 45'h1FFF_FFFF_FFFB};
        vecs[1] = '{c_all: 1,  c_tap: -1, c_val: 0,  s_all: 1,  s_tap: -1, s_val: 0,   exp: 45'd35};
        vecs[2] = '{c_all: -1, c_tap: -1, c_val: 0,  s_all: 64'sd549755813887, s_tap: -1, s_val: 0,
                    exp: 45'h0E80_0000_0023};
        vecs[3] = '{c_all: 2,  c_tap: -1, c_val: 0,  s_all: -3, s_tap: -1, s_val: 0,   exp: 45'h1FFF_FFFF_FF2E};
        vecs[4] = '{c_all: 0,  c_tap: 0,  c_val: 64'sd4294967295, s_all: 0, s_tap: 0,
                    s_val: -64'sd549755813888, exp: 45'h0080_0000_0000};
        vecs[5] = '{c_all: 0,  c_tap: 34, c_val: -7, s_all: 9,  s_tap: 34, s_val: 100, exp: 45'h1FFF_FFFF_FD44};
        vecs[6] = '{c_all: 1,  c_tap: 3,  c_val: 1000, s_all: -1, s_tap: 3, s_val: 4,  exp: 45'd3966};

        reset = 1'b1;
        cw = 1'b0;
        ca = '0;
        cd = '0;
        push_samp = 1'b0;
        samp = '0;
        stopout = 1'b0;
        repeat (3) tick();
        check("reset_pushout", 64'(pushout), 64'd0);
        check("reset_res", 64'(res), 64'd0);
        check("reset_samp_ready", 64'(samp_ready), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", 64'(samp_ready), 64'd1);

        // Single windows: value and accept-to-pushout latency (LAT+1 = 10)
        for (int i = 0; i < 7; i++) begin
            load_coefs(vecs[i].c_all, vecs[i].c_tap, vecs[i].c_val);
            samp = build_win(vecs[i].s_all, vecs[i].s_tap, vecs[i].s_val);
            push_samp = 1'b1;
            tick();
            push_samp = 1'b0;
            n = 0;
            while (!pushout && n < 30) begin
                tick();
                n++;
            end
            check($sformatf("vec%0d_latency", i), 64'(n), 64'd10);
            check($sformatf("vec%0d_res", i), 64'(res), 64'(vecs[i].exp));
            tick();
            check($sformatf("vec%0d_single_pop", i), 64'(pushout), 64'd0);
        end

        // Double buffer: shadow write alone has no effect; commit alongside a push applies to it
        load_coefs(1, -1, 0);
        cw = 1'b1;
        ca = 6'd0;
        cd = CW'(7);
        tick();
        cw = 1'b0;
        samp = build_win(1, -1, 0);
        push_samp = 1'b1;
        tick();
        cw = 1'b1;
        ca = 6'(NT);
        tick();
        cw = 1'b0;
        ca = '0;
        tick();
        push_samp = 1'b0;
        exp_q.push_back(45'd35);
        exp_q.push_back(45'd41);
        exp_q.push_back(45'd41);
        run_stream(0, 0, 0, 0, 60);

        // Streams with random sink stalls, including sustained full-credit operation
        load_coefs(1, -1, 0);
        run_stream(24, 50, 35, -300, 1500);
        run_stream(70, 75, 35, 500, 4000);

        // Credit: sink stalled, push whenever ready
        stopout = 1'b1;
        acc = 0;
        first_block = -1;
        for (int j = 0; j < 40; j++) begin
            if (samp_ready) begin
                push_samp = 1'b1;
                samp = build_win(longint'(acc + 1), -1, 0);
                exp_q.push_back(RW'(35 * (acc + 1)));
                acc++;
            end else begin
                push_samp = 1'b0;
                if (first_block < 0) first_block = j;
            end
            tick();
        end
        push_samp = 1'b0;
        repeat (15) tick();
        check("credit_accepted", 64'(acc), 64'd32);
        check("credit_first_block", 64'(first_block), 64'd32);
        check("credit_ready_low", 64'(samp_ready), 64'd0);
        check("credit_err_clear", 64'(err), 64'd0);
        check("credit_head_valid", 64'(pushout), 64'd1);

        // Overflow: push while not ready sets err, adds nothing
        push_samp = 1'b1;
        samp = build_win(999, -1, 0);
        tick();
        push_samp = 1'b0;
        check("overflow_err_set", 64'(err), 64'd1);
        run_stream(0, 0, 0, 0, 200);
        cnt = 0;
        repeat (12) begin
            if (pushout) cnt++;
            tick();
        end
        check("overflow_no_extra", 64'(cnt), 64'd0);
        check("overflow_err_sticky", 64'(err), 64'd1);
        check("ready_after_drain", 64'(samp_ready), 64'd1);

        // Reset with 3 results queued and 5 windows in flight
        load_coefs(2, -1, 0);
        stopout = 1'b1;
        for (int j = 0; j < 8; j++) begin
            push_samp = 1'b1;
            samp = build_win(longint'(j + 1), -1, 0);
            tick();
        end
        push_samp = 1'b0;
        repeat (4) tick();
        check("prereset_head_valid", 64'(pushout), 64'd1);
        reset = 1'b1;
        tick();
        check("midrun_reset_pushout", 64'(pushout), 64'd0);
        check("midrun_reset_res", 64'(res), 64'd0);
        check("midrun_reset_ready", 64'(samp_ready), 64'd0);
        check("midrun_reset_err", 64'(err), 64'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (30) begin
            stopout = ($urandom_range(99) < 50);
            if (pushout) cnt++;
            tick();
        end
        stopout = 1'b0;
        check("no_stale_result", 64'(cnt), 64'd0);
        check("ready_after_midrun_reset", 64'(samp_ready), 64'd1);
        // Coefficient banks were cleared, so every result is zero
        run_stream(3, 50, 0, 10, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
